arm7tdmi_dp_ctrl: RTL and testbench

ARM7TDMI_DP_CTRL -- requirements
Module: arm7tdmi_dp_ctrl

---
 rtl/arm7tdmi_pkg.sv | 47 ++++
 rtl/arm7tdmi_alu.sv | 72 +++++++
 rtl/arm7tdmi_dp_ctrl.sv | 178 +++++++++++++++++
 tb/tb_arm7tdmi_dp_ctrl.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm7tdmi_pkg.sv
// Shared types for the ARM7TDMI data-processing path: ALU operations,
// controller state encoding and opcode classification helpers.
package arm7tdmi_pkg;

  typedef enum logic [3:0] {
    ALU_AND = 4'd0,
    ALU_EOR = 4'd1,
    ALU_SUB = 4'd2,
    ALU_RSB = 4'd3,
    ALU_ADD = 4'd4,
    ALU_ADC = 4'd5,
    ALU_SBC = 4'd6,
    ALU_RSC = 4'd7,
    ALU_TST = 4'd8,
    ALU_TEQ = 4'd9,
    ALU_CMP = 4'd10,
    ALU_CMN = 4'd11,
    ALU_ORR = 4'd12,
    ALU_MOV = 4'd13,
    ALU_BIC = 4'd14,
    ALU_MVN = 4'd15
  } alu_op_t;

  typedef enum logic [1:0] {
    DP_IDLE  = 2'd0,
    DP_EXEC  = 2'd1,
    DP_WB    = 2'd2,
    DP_FLUSH = 2'd3
  } dp_state_t;

  // The instruction opcode field already uses the ALU operation ordering.
  function automatic alu_op_t dp_opcode_to_alu_op(input logic [3:0] opcode);
    return alu_op_t'(opcode);
  endfunction

  // Logical ops take C from the shifter and keep V.
  function automatic logic alu_op_is_logical(input alu_op_t op);
    return op inside {ALU_AND, ALU_EOR, ALU_TST, ALU_TEQ,
                      ALU_ORR, ALU_MOV, ALU_BIC, ALU_MVN};
  endfunction

  // Compare/test ops only produce flags, never a register result.
  function automatic logic alu_op_is_test(input alu_op_t op);
    return op inside {ALU_TST, ALU_TEQ, ALU_CMP, ALU_CMN};
  endfunction

endpackage

// File: rtl/arm7tdmi_alu.sv
// 32-bit ARM data-processing ALU. Result and NZCV are combinational; when
// set_flags is high the ALU runs standalone and tracks its own C and V.
module arm7tdmi_alu
  import arm7tdmi_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        set_flags,
  input  alu_op_t     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        carry_in,
  input  logic        v_in,
  output logic [31:0] result,
  output logic [3:0]  flags
);

  logic        c_hold_reg;
  logic        v_hold_reg;
  logic        c_src;
  logic        v_src;
  logic [31:0] x;
  logic [31:0] y;
  logic [31:0] logic_res;
  logic        cin;
  logic        arith;
  logic [32:0] sum;

  assign c_src = set_flags ? c_hold_reg : carry_in;
  assign v_src = set_flags ? v_hold_reg : v_in;

  // Subtractions are formed as x + ~y + carry so C is the ARM not-borrow.
  always_comb begin
    x         = '0;
    y         = '0;
    cin       = 1'b0;
    arith     = 1'b1;
    logic_res = '0;
    case (op)
      ALU_SUB, ALU_CMP: begin x = a; y = ~b; cin = 1'b1;  end
      ALU_RSB:          begin x = b; y = ~a; cin = 1'b1;  end
      ALU_ADD, ALU_CMN: begin x = a; y = b;  cin = 1'b0;  end
      ALU_ADC:          begin x = a; y = b;  cin = c_src; end
      ALU_SBC:          begin x = a; y = ~b; cin = c_src; end
      ALU_RSC:          begin x = b; y = ~a; cin = c_src; end
      ALU_AND, ALU_TST: begin arith = 1'b0; logic_res = a & b;  end
      ALU_EOR, ALU_TEQ: begin arith = 1'b0; logic_res = a ^ b;  end
      ALU_ORR:          begin arith = 1'b0; logic_res = a | b;  end
      ALU_MOV:          begin arith = 1'b0; logic_res = b;      end
      ALU_BIC:          begin arith = 1'b0; logic_res = a & ~b; end
      default:          begin arith = 1'b0; logic_res = ~b;     end
    endcase
    sum    = {1'b0, x} + {1'b0, y} + {32'd0, cin};
    result = arith ? sum[31:0] : logic_res;
    flags[3] = result[31];
    flags[2] = (result == 32'd0);
    flags[1] = arith ? sum[32] : carry_in;
    flags[0] = arith ? ((x[31] == y[31]) && (sum[31] != x[31])) : v_src;
  end

  // Standalone C/V tracking, only loaded while set_flags is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_hold_reg <= 1'b0;
      v_hold_reg <= 1'b0;
    end else if (set_flags) begin
      c_hold_reg <= flags[1];
      v_hold_reg <= flags[0];
    end
  end

endmodule

// File: rtl/arm7tdmi_dp_ctrl.sv
// Data-processing instruction controller: accepts one instruction, runs it
// through the ALU, and issues register/flag write-back and PC-write flush.
module arm7tdmi_dp_ctrl
  import arm7tdmi_pkg::*;
#(
  parameter int PC_FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] instr,
  input  logic        cond_pass,
  input  logic [31:0] rn_data,
  input  logic [31:0] op2_data,
  input  logic        shifter_carry,
  input  logic [3:0]  cpsr_flags,
  output logic        wb_valid,
  output logic [3:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        flags_we,
  output logic [3:0]  flags_out,
  output logic        spsr_restore,
  output logic        flush,
  output logic        busy
);

  localparam int CNT_W = $clog2(PC_FLUSH_CYCLES + 1);

  dp_state_t   state_reg;
  alu_op_t     op_reg;
  logic        s_reg;
  logic [3:0]  rd_reg;
  logic        cond_reg;
  logic [31:0] rn_reg;
  logic [31:0] op2_reg;
  logic        sc_reg;
  logic        c_reg;
  logic        v_reg;
  logic [CNT_W-1:0] flush_cnt_reg;

  logic        accept;
  logic        is_test;
  logic        writes_rd;
  logic        pc_write;
  logic        flags_upd;
  logic        alu_cin;
  logic [31:0] alu_result;
  logic [3:0]  alu_flags;
  logic        instr_unused;

  // Only opcode, S and Rd matter here; N and Z of the old CPSR are never read.
  assign instr_unused = ^{instr[31:25], instr[19:16], instr[11:0], cpsr_flags[3:2]};

  assign accept    = req_valid & req_ready;
  assign is_test   = alu_op_is_test(op_reg);
  assign writes_rd = cond_reg & ~is_test;
  assign pc_write  = writes_rd & (rd_reg == 4'd15);
  assign flags_upd = cond_reg & s_reg & ~pc_write;
  assign alu_cin   = alu_op_is_logical(op_reg) ? sc_reg : c_reg;

  arm7tdmi_alu u_alu (
    .clk       (clk),
    .rst_n     (~rst),
    .set_flags (1'b0),
    .op        (op_reg),
    .a         (rn_reg),
    .b         (op2_reg),
    .carry_in  (alu_cin),
    .v_in      (v_reg),
    .result    (alu_result),
    .flags     (alu_flags)
  );

  // Controller FSM with operand capture and registered write-back outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= DP_IDLE;
      op_reg        <= ALU_AND;
      s_reg         <= 1'b0;
      rd_reg        <= '0;
      cond_reg      <= 1'b0;
      rn_reg        <= '0;
      op2_reg       <= '0;
      sc_reg        <= 1'b0;
      c_reg         <= 1'b0;
      v_reg         <= 1'b0;
      flush_cnt_reg <= '0;
      req_ready     <= 1'b0;
      wb_valid      <= 1'b0;
      wb_rd         <= '0;
      wb_data       <= '0;
      flags_we      <= 1'b0;
      flags_out     <= '0;
      spsr_restore  <= 1'b0;
      flush         <= 1'b0;
      busy          <= 1'b0;
    end else begin
      wb_valid     <= 1'b0;
      wb_rd        <= '0;
      wb_data      <= '0;
      flags_we     <= 1'b0;
      flags_out    <= '0;
      spsr_restore <= 1'b0;
      flush        <= 1'b0;
      if (accept) begin
        op_reg   <= dp_opcode_to_alu_op(instr[24:21]);
        s_reg    <= instr[20];
        rd_reg   <= instr[15:12];
        cond_reg <= cond_pass;
        rn_reg   <= rn_data;
        op2_reg  <= op2_data;
        sc_reg   <= shifter_carry;
        c_reg    <= cpsr_flags[1];
        v_reg    <= cpsr_flags[0];
      end
      case (state_reg)
        DP_IDLE: begin
          if (accept) begin
            state_reg <= DP_EXEC;
            req_ready <= 1'b0;
            busy      <= 1'b1;
          end else begin
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        DP_EXEC: begin
          state_reg    <= DP_WB;
          wb_valid     <= writes_rd;
          wb_rd        <= writes_rd ? rd_reg : 4'd0;
          wb_data      <= writes_rd ? alu_result : 32'd0;
          flags_we     <= flags_upd;
          flags_out    <= flags_upd ? alu_flags : 4'd0;
          spsr_restore <= pc_write & s_reg;
          flush        <= pc_write;
          req_ready    <= ~pc_write;
          busy         <= 1'b1;
          if (pc_write) begin
            flush_cnt_reg <= CNT_W'(PC_FLUSH_CYCLES - 1);
          end
        end
        DP_WB: begin
          if (accept) begin
            state_reg <= DP_EXEC;
            req_ready <= 1'b0;
            busy      <= 1'b1;
          end else if (flush) begin
            state_reg <= DP_FLUSH;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (flush_cnt_reg != '0) begin
              flush         <= 1'b1;
              flush_cnt_reg <= flush_cnt_reg - CNT_W'(1);
            end
          end else begin
            state_reg <= DP_IDLE;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          if (flush_cnt_reg != '0) begin
            flush         <= 1'b1;
            flush_cnt_reg <= flush_cnt_reg - CNT_W'(1);
            req_ready     <= 1'b0;
            busy          <= 1'b1;
          end else begin
            state_reg <= DP_IDLE;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arm7tdmi_dp_ctrl.sv
// Self-checking bench for arm7tdmi_dp_ctrl: directed corner cases plus
// randomized instructions checked against an arithmetic reference model.
module tb_arm7tdmi_dp_ctrl;

  localparam int FLUSH_N = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] instr = '0;
  logic        cond_pass = 1'b0;
  logic [31:0] rn_data = '0;
  logic [31:0] op2_data = '0;
  logic        shifter_carry = 1'b0;
  logic [3:0]  cpsr_flags = '0;
  logic        wb_valid;
  logic [3:0]  wb_rd;
  logic [31:0] wb_data;
  logic        flags_we;
  logic [3:0]  flags_out;
  logic        spsr_restore;
  logic        flush;
  logic        busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  arm7tdmi_dp_ctrl #(.PC_FLUSH_CYCLES(FLUSH_N)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .instr         (instr),
    .cond_pass     (cond_pass),
    .rn_data       (rn_data),
    .op2_data      (op2_data),
    .shifter_carry (shifter_carry),
    .cpsr_flags    (cpsr_flags),
    .wb_valid      (wb_valid),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .flags_we      (flags_we),
    .flags_out     (flags_out),
    .spsr_restore  (spsr_restore),
    .flush         (flush),
    .busy          (busy)
  );

  typedef struct packed {
    logic        wv;
    logic [3:0]  rd;
    logic [31:0] data;
    logic        fwe;
    logic [3:0]  fo;
    logic        spsr;
    logic        fl;
  } exp_t;

  // Reference: ARM semantics via wide signed/unsigned arithmetic.
  function automatic exp_t model(input logic [31:0] ins, input logic cp,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic sc, input logic [3:0] cpsr);
    exp_t e;
    logic [3:0] opc;
    logic s, c, v, test, writes, pc;
    logic [3:0] rd;
    logic [31:0] r;
    longint ua, ub, sa, sb, nb, ut, st;
    bit arith, is_sub;
    opc = ins[24:21]; s = ins[20]; rd = ins[15:12];
    ua = longint'(a); ub = longint'(b);
    sa = longint'($signed(a)); sb = longint'($signed(b));
    nb = cpsr[1] ? 0 : 1;
    arith = 1; is_sub = 0; ut = 0; st = 0; r = '0;
    case (opc)
      4'd0, 4'd8:  begin arith = 0; r = a & b; end
      4'd1, 4'd9:  begin arith = 0; r = a ^ b; end
      4'd12:       begin arith = 0; r = a | b; end
      4'd13:       begin arith = 0; r = b; end
      4'd14:       begin arith = 0; r = a & ~b; end
      4'd15:       begin arith = 0; r = ~b; end
      4'd2, 4'd10: begin ut = ua - ub; st = sa - sb; is_sub = 1; end
      4'd3:        begin ut = ub - ua; st = sb - sa; is_sub = 1; end
      4'd4, 4'd11: begin ut = ua + ub; st = sa + sb; end
      4'd5:        begin ut = ua + ub + (1 - nb); st = sa + sb + (1 - nb); end
      4'd6:        begin ut = ua - ub - nb; st = sa - sb - nb; is_sub = 1; end
      default:     begin ut = ub - ua - nb; st = sb - sa - nb; is_sub = 1; end
    endcase
    if (arith) begin
      r = ut[31:0];
      c = is_sub ? (ut >= 0) : (ut > 64'sd4294967295);
      v = (st > 64'sd2147483647) || (st < -64'sd2147483648);
    end else begin
      c = sc;
      v = cpsr[0];
    end
    test   = (opc >= 4'd8) && (opc <= 4'd11);
    writes = cp && !test;
    pc     = writes && (rd == 4'd15);
    e.wv   = writes;
    e.rd   = writes ? rd : 4'd0;
    e.data = writes ? r : 32'd0;
    e.fwe  = cp && s && !pc;
    e.fo   = e.fwe ? {r[31], r == 32'd0, c, v} : 4'd0;
    e.spsr = pc && s;
    e.fl   = pc;
    return e;
  endfunction

  function automatic logic [31:0] mk_instr(input logic [3:0] opc, input logic s,
                                           input logic [3:0] rd);
    logic [31:0] i;
    i = 32'hE000_0000;
    i[24:21] = opc;
    i[20] = s;
    i[15:12] = rd;
    return i;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  // Offer one instruction (called at a negedge); returns at the negedge in EXEC.
  task automatic send(input logic [31:0] ins, input logic cp, input logic [31:0] a,
                      input logic [31:0] b, input logic sc, input logic [3:0] cpsr,
                      output bit ok);
    int n;
    n = 0;
    instr = ins; cond_pass = cp; rn_data = a; op2_data = b;
    shifter_carry = sc; cpsr_flags = cpsr; req_valid = 1'b1;
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    ok = (req_ready === 1'b1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    instr = $urandom; rn_data = $urandom; op2_data = $urandom;
    cond_pass = 1'($urandom); shifter_carry = 1'($urandom); cpsr_flags = 4'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({req_ready, wb_valid, wb_rd, wb_data, flags_we, flags_out, spsr_restore, flush, busy} !== 46'd0)
      begin fails++; $display("FAIL reset_outputs: got %h required 0",
        {req_ready, wb_valid, wb_rd, wb_data, flags_we, flags_out, spsr_restore, flush, busy}); end
    req_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if ({req_ready, busy} !== 2'b10)
      begin fails++; $display("FAIL reset_release: ready/busy got %b required 10", {req_ready, busy}); end
    $display("[TB] reset checked");
  endtask

  task automatic test_adds();
    bit ok;
    send(mk_instr(4'd4, 1'b1, 4'd1), 1'b1, 32'h7FFF_FFFF, 32'h1, 1'b0, 4'b0000, ok);
    tests++;
    if (!ok || wb_valid !== 1'b0 || busy !== 1'b1)
      begin fails++; $display("FAIL adds_exec: ok=%0d wb_valid=%b busy=%b required 1/0/1", ok, wb_valid, busy); end
    @(negedge clk);
    tests++;
    if ({wb_valid, wb_rd, wb_data} !== {1'b1, 4'd1, 32'h8000_0000})
      begin fails++; $display("FAIL adds_wb: got %b/%0d/%h required 1/1/80000000", wb_valid, wb_rd, wb_data); end
    tests++;
    if ({flags_we, flags_out, spsr_restore, flush} !== {1'b1, 4'b1001, 1'b0, 1'b0})
      begin fails++; $display("FAIL adds_flags: we=%b flags=%b spsr=%b flush=%b required 1/1001/0/0",
        flags_we, flags_out, spsr_restore, flush); end
    @(negedge clk);
    tests++;
    if ({wb_valid, flags_we, busy, req_ready} !== 4'b0001)
      begin fails++; $display("FAIL adds_idle: got %b required 0001", {wb_valid, flags_we, busy, req_ready}); end
    $display("[TB] ADDS R1 checked");
  endtask

  task automatic test_cmp();
    bit ok;
    send(mk_instr(4'd10, 1'b1, 4'd0), 1'b1, 32'd5, 32'd5, 1'b0, 4'b0000, ok);
    @(negedge clk);
    tests++;
    if ({ok, wb_valid, flags_we, flags_out} !== {1'b1, 1'b0, 1'b1, 4'b0110})
      begin fails++; $display("FAIL cmp_wb: ok=%0d wb_valid=%b we=%b flags=%b required 1/0/1/0110",
        ok, wb_valid, flags_we, flags_out); end
    @(negedge clk);
    $display("[TB] CMP checked");
  endtask

  task automatic test_ands();
    bit ok;
    send(mk_instr(4'd0, 1'b1, 4'd2), 1'b1, 32'hF0, 32'h0F, 1'b1, 4'b0001, ok);
    @(negedge clk);
    tests++;
    if ({ok, wb_valid, wb_data, flags_we, flags_out} !== {1'b1, 1'b1, 32'h0, 1'b1, 4'b0111})
      begin fails++; $display("FAIL ands_wb: ok=%0d wv=%b data=%h we=%b flags=%b required 1/1/0/1/0111",
        ok, wb_valid, wb_data, flags_we, flags_out); end
    @(negedge clk);
    $display("[TB] ANDS checked");
  endtask

  task automatic test_adcs();
    bit ok;
    send(mk_instr(4'd5, 1'b1, 4'd3), 1'b1, 32'hFFFF_FFFF, 32'h0, 1'b0, 4'b0010, ok);
    @(negedge clk);
    tests++;
    if ({ok, wb_valid, wb_data, flags_we, flags_out} !== {1'b1, 1'b1, 32'h0, 1'b1, 4'b0110})
      begin fails++; $display("FAIL adcs_wb: ok=%0d wv=%b data=%h we=%b flags=%b required 1/1/0/1/0110",
        ok, wb_valid, wb_data, flags_we, flags_out); end
    @(negedge clk);
    $display("[TB] ADCS checked");
  endtask

  task automatic test_movs_pc();
    bit ok;
    send(mk_instr(4'd13, 1'b1, 4'd15), 1'b1, 32'h0, 32'h100, 1'b0, 4'b0000, ok);
    req_valid = 1'b1;
    @(negedge clk);
    tests++;
    if ({ok, wb_valid, wb_rd, wb_data, spsr_restore, flags_we} !== {1'b1, 1'b1, 4'd15, 32'h100, 1'b1, 1'b0})
      begin fails++; $display("FAIL movs_wb: ok=%0d wv=%b rd=%0d data=%h spsr=%b we=%b required 1/1/15/100/1/0",
        ok, wb_valid, wb_rd, wb_data, spsr_restore, flags_we); end
    tests++;
    if ({flush, req_ready} !== 2'b10)
      begin fails++; $display("FAIL movs_flush_wb: flush/ready got %b required 10", {flush, req_ready}); end
    @(negedge clk);
    tests++;
    if ({flush, req_ready, spsr_restore, wb_valid, busy} !== 5'b10001)
      begin fails++; $display("FAIL movs_flush2: got %b required 10001",
        {flush, req_ready, spsr_restore, wb_valid, busy}); end
    req_valid = 1'b0;
    @(negedge clk);
    tests++;
    if ({flush, req_ready, busy} !== 3'b010)
      begin fails++; $display("FAIL movs_idle: flush/ready/busy got %b required 010", {flush, req_ready, busy}); end
    $display("[TB] MOVS PC checked");
  endtask

  task automatic test_back_to_back();
    bit ok;
    send(mk_instr(4'd4, 1'b0, 4'd2), 1'b1, 32'd10, 32'd20, 1'b0, 4'b0000, ok);
    instr = mk_instr(4'd2, 1'b0, 4'd3); cond_pass = 1'b1;
    rn_data = 32'd100; op2_data = 32'd1; req_valid = 1'b1;
    @(negedge clk);
    tests++;
    if ({ok, wb_valid, wb_rd, wb_data, req_ready} !== {1'b1, 1'b1, 4'd2, 32'd30, 1'b1})
      begin fails++; $display("FAIL b2b_first: ok=%0d wv=%b rd=%0d data=%h ready=%b required 1/1/2/1e/1",
        ok, wb_valid, wb_rd, wb_data, req_ready); end
    @(negedge clk);
    req_valid = 1'b0;
    tests++;
    if ({wb_valid, req_ready, busy} !== 3'b001)
      begin fails++; $display("FAIL b2b_exec: wv/ready/busy got %b required 001", {wb_valid, req_ready, busy}); end
    @(negedge clk);
    tests++;
    if ({wb_valid, wb_rd, wb_data} !== {1'b1, 4'd3, 32'd99})
      begin fails++; $display("FAIL b2b_second: wv=%b rd=%0d data=%h required 1/3/63", wb_valid, wb_rd, wb_data); end
    @(negedge clk);
    // Reset pulsed while an instruction sits in EXEC.
    send(mk_instr(4'd4, 1'b1, 4'd4), 1'b1, 32'd1, 32'd1, 1'b0, 4'b0000, ok);
    rst = 1'b1;
    #1;
    tests++;
    if ({req_ready, wb_valid, wb_rd, wb_data, flags_we, flags_out, spsr_restore, flush, busy} !== 46'd0)
      begin fails++; $display("FAIL rst_exec_async: got %h required 0",
        {req_ready, wb_valid, wb_rd, wb_data, flags_we, flags_out, spsr_restore, flush, busy}); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if ({req_ready, wb_valid, flags_we, busy} !== 4'b1000)
      begin fails++; $display("FAIL rst_exec_release: ready/wv/we/busy got %b required 1000",
        {req_ready, wb_valid, flags_we, busy}); end
    $display("[TB] back-to-back and mid-EXEC reset checked");
  endtask

  task automatic test_random();
    bit ok, bad_ready;
    exp_t e;
    logic [31:0] ins, a, b;
    logic cp, sc;
    logic [3:0] cpsr;
    int nfl;
    for (int k = 0; k < 80; k++) begin
      ins = $urandom;
      if ($urandom_range(0, 3) == 0) ins[15:12] = 4'd15;
      cp = ($urandom_range(0, 4) != 0);
      a = pick_operand(); b = pick_operand();
      sc = 1'($urandom); cpsr = 4'($urandom);
      e = model(ins, cp, a, b, sc, cpsr);
      send(ins, cp, a, b, sc, cpsr, ok);
      tests++;
      if (!ok || wb_valid !== 1'b0 || flush !== 1'b0)
        begin fails++; $display("FAIL rand_exec[%0d]: ok=%0d wv=%b flush=%b required 1/0/0", k, ok, wb_valid, flush); end
      @(negedge clk);
      $display("[TB] txn %0d op=%0d s=%0d rd=%0d cp=%0d a=%h b=%h -> wv=%b data=%h flags=%b",
               k, ins[24:21], ins[20], ins[15:12], cp, a, b, wb_valid, wb_data, flags_out);
      tests++;
      if ({wb_valid, wb_rd, wb_data} !== {e.wv, e.rd, e.data})
        begin fails++; $display("FAIL rand_wb[%0d]: got %b/%0d/%h required %b/%0d/%h",
          k, wb_valid, wb_rd, wb_data, e.wv, e.rd, e.data); end
      tests++;
      if ({flags_we, flags_out, spsr_restore, flush, req_ready} !== {e.fwe, e.fo, e.spsr, e.fl, !e.fl})
        begin fails++; $display("FAIL rand_flags[%0d]: got we=%b f=%b spsr=%b fl=%b rdy=%b required %b/%b/%b/%b/%b",
          k, flags_we, flags_out, spsr_restore, flush, req_ready, e.fwe, e.fo, e.spsr, e.fl, !e.fl); end
      if (e.fl) begin
        nfl = 1; bad_ready = 0;
        for (int w = 0; w < 10; w++) begin
          @(negedge clk);
          if (flush !== 1'b1) break;
          nfl++;
          if (req_ready !== 1'b0) bad_ready = 1;
        end
        tests++;
        if (nfl != FLUSH_N || bad_ready || req_ready !== 1'b1 || busy !== 1'b0)
          begin fails++; $display("FAIL rand_flush[%0d]: cycles=%0d bad_ready=%0d ready=%b busy=%b required %0d/0/1/0",
            k, nfl, bad_ready, req_ready, busy, FLUSH_N); end
      end else begin
        @(negedge clk);
        tests++;
        if ({busy, req_ready, wb_valid} !== 3'b010)
          begin fails++; $display("FAIL rand_idle[%0d]: busy/ready/wv got %b required 010", k, {busy, req_ready, wb_valid}); end
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_adds();
    test_cmp();
    test_ands();
    test_adcs();
    test_movs_pc();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion before 200000");
    $fatal(1, "timeout");
  end

endmodule
